// File: rtl/wb_stage_if.sv
// MEM->WB bus and register-file write port of wb_stage.
// LOAD_EXT_EN adds the load-type and byte-offset fields.
interface wb_stage_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;

    logic            mem_valid;
    logic            mem_regWrite;
    logic            mem_memToReg;
    logic            mem_link;
    logic [RA_W-1:0] mem_write_register;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_read_data;
    logic [XLEN-1:0] mem_pc_plus4;
`ifdef LOAD_EXT_EN
    logic [1:0]      mem_load_type;
    logic [1:0]      mem_byte_off;
`endif
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;

    logic            regWrite;
    logic [RA_W-1:0] write_register;
    logic [XLEN-1:0] write_data;
    logic            wb_valid;
    logic            bypass_rs;
    logic            bypass_rt;

    // Upstream side: MEM stage and ID read addresses
    modport master (
`ifdef LOAD_EXT_EN
        output mem_load_type, mem_byte_off,
`endif
        output mem_valid, mem_regWrite, mem_memToReg, mem_link, mem_write_register,
        output mem_alu_result, mem_read_data, mem_pc_plus4, id_rs, id_rt,
        input  regWrite, write_register, write_data, wb_valid, bypass_rs, bypass_rt
    );

    modport slave (
`ifdef LOAD_EXT_EN
        input  mem_load_type, mem_byte_off,
`endif
        input  mem_valid, mem_regWrite, mem_memToReg, mem_link, mem_write_register,
        input  mem_alu_result, mem_read_data, mem_pc_plus4, id_rs, id_rt,
        output regWrite, write_register, write_data, wb_valid, bypass_rs, bypass_rt
    );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, register-file writeback driver, ID bypass and retire counter.
// Optional LOAD_EXT_EN: sub-word load extraction (lb/lbu/lh/lhu) before the writeback select.
module wb_stage #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    wb_stage_if.slave        bus,
    output logic [CNT_W-1:0] retired_count
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;

    logic            wb_valid_q;
    logic            wb_reg_write_q;
    logic            wb_mem_to_reg_q;
    logic            wb_link_q;
    logic [RA_W-1:0] wb_rd_q;
    logic [XLEN-1:0] wb_alu_q;
    logic [XLEN-1:0] wb_rdata_q;
    logic [XLEN-1:0] wb_pc4_q;
`ifdef LOAD_EXT_EN
    logic [1:0]      wb_load_type_q;
    logic [1:0]      wb_byte_off_q;
`endif

    logic            wr_en;
    logic [XLEN-1:0] load_data;
    logic            retire;

    // WB register: reset > flush > stall > capture
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_link_q       <= 1'b0;
            wb_rd_q         <= '0;
            wb_alu_q        <= '0;
            wb_rdata_q      <= '0;
            wb_pc4_q        <= '0;
`ifdef LOAD_EXT_EN
            wb_load_type_q  <= '0;
            wb_byte_off_q   <= '0;
`endif
        end else if (!stall) begin
            wb_valid_q      <= bus.mem_valid;
            wb_reg_write_q  <= bus.mem_regWrite;
            wb_mem_to_reg_q <= bus.mem_memToReg;
            wb_link_q       <= bus.mem_link;
            wb_rd_q         <= bus.mem_write_register;
            wb_alu_q        <= bus.mem_alu_result;
            wb_rdata_q      <= bus.mem_read_data;
            wb_pc4_q        <= bus.mem_pc_plus4;
`ifdef LOAD_EXT_EN
            wb_load_type_q  <= bus.mem_load_type;
            wb_byte_off_q   <= bus.mem_byte_off;
`endif
        end
    end

    // An entry leaves WB (and is counted once) when it is not held by stall, or is flushed
    assign retire = wb_valid_q & (~stall | flush);

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count <= '0;
        end else if (retire) begin
            retired_count <= retired_count + CNT_W'(1);
        end
    end

`ifdef LOAD_EXT_EN
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Little-endian extraction; for type 11 byte_off[0] is the halfword signed flag
    always_comb begin
        load_byte = 8'(wb_rdata_q >> {wb_byte_off_q, 3'b000});
        load_half = wb_byte_off_q[1] ? wb_rdata_q[31:16] : wb_rdata_q[15:0];
        case (wb_load_type_q)
            2'b00:   load_data = wb_rdata_q;
            2'b01:   load_data = {{24{load_byte[7]}}, load_byte};
            2'b10:   load_data = {24'b0, load_byte};
            default: load_data = {{16{wb_byte_off_q[0] & load_half[15]}}, load_half};
        endcase
    end
`else
    assign load_data = wb_rdata_q;
`endif

    // $0 is never written, so bypass can never hit on $0 either
    assign wr_en = wb_valid_q & wb_reg_write_q & (wb_rd_q != '0);

    always_comb begin
        bus.regWrite       = wr_en;
        bus.wb_valid       = wb_valid_q;
        bus.write_register = '0;
        bus.write_data     = '0;
        if (wb_valid_q) begin
            bus.write_register = wb_rd_q;
            if (wb_link_q) begin
                bus.write_data = wb_pc4_q;
            end else if (wb_mem_to_reg_q) begin
                bus.write_data = load_data;
            end else begin
                bus.write_data = wb_alu_q;
            end
        end
    end

    assign bus.bypass_rs = wr_en & (bus.id_rs == wb_rd_q);
    assign bus.bypass_rt = wr_en & (bus.id_rt == wb_rd_q);
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed scenarios followed by random traffic.
module tb_wb_stage;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic             flush;
    logic [CNT_W-1:0] retired_count;

    wb_stage_if bus ();

    wb_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .flush(flush),
        .bus(bus),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst, stl, fls, valid, rw, m2r, link;
        bit [4:0]  rd, id_rs, id_rt;
        bit [31:0] alu, rdata, pc4;
        bit [1:0]  lt, off;
    } stim_t;

    typedef struct {
        bit        rw;
        bit [4:0]  wreg;
        bit [31:0] wdata;
        bit        valid, brs, brt;
        int        cnt;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: one instruction slot holding its already-resolved write value
    bit        m_known = 0;
    bit        m_valid, m_rw;
    bit [4:0]  m_rd;
    bit [31:0] m_data;
    int        m_cnt;

    function automatic bit [31:0] load_value(bit [31:0] w, bit [1:0] lt, bit [1:0] off);
        int unsigned b, h;
`ifdef LOAD_EXT_EN
        b = (w / (32'd1 << (8 * off))) % 256;
        h = off[1] ? (w / 65536) : (w % 65536);
        case (lt)
            2'd0: return w;
            2'd1: return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
            2'd2: return 32'(b);
            default: return (off[0] && h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
        endcase
`else
        b = 0; h = 0;
        return w + 32'(b + h);
`endif
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        @(negedge clk);
        reset = s.rst; stall = s.stl; flush = s.fls;
        bus.mem_valid = s.valid; bus.mem_regWrite = s.rw; bus.mem_memToReg = s.m2r;
        bus.mem_link = s.link; bus.mem_write_register = s.rd;
        bus.mem_alu_result = s.alu; bus.mem_read_data = s.rdata; bus.mem_pc_plus4 = s.pc4;
`ifdef LOAD_EXT_EN
        bus.mem_load_type = s.lt; bus.mem_byte_off = s.off;
`endif
        bus.id_rs = s.id_rs; bus.id_rt = s.id_rt;
        if (m_known) begin
            e.valid = m_valid;
            e.rw    = m_valid && m_rw && m_rd != 0;
            e.wreg  = m_valid ? m_rd : 5'd0;
            e.wdata = m_valid ? m_data : 32'd0;
            e.brs   = e.rw && s.id_rs == m_rd;
            e.brt   = e.rw && s.id_rt == m_rd;
            e.cnt   = m_cnt;
            expq.push_back(e);
        end
        if (s.rst) begin
            m_known = 1; m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0; m_cnt = 0;
        end else if (m_known) begin
            if (m_valid && (!s.stl || s.fls)) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (s.fls) begin
                m_valid = 0; m_rw = 0; m_rd = 0; m_data = 0;
            end else if (!s.stl) begin
                m_valid = s.valid; m_rw = s.rw; m_rd = s.rd;
                m_data  = s.link ? s.pc4 : s.m2r ? load_value(s.rdata, s.lt, s.off) : s.alu;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("regWrite",       32'(bus.regWrite),       32'(e.rw));
                check("write_register", 32'(bus.write_register), 32'(e.wreg));
                check("write_data",     bus.write_data,          e.wdata);
                check("wb_valid",       32'(bus.wb_valid),       32'(e.valid));
                check("bypass_rs",      32'(bus.bypass_rs),      32'(e.brs));
                check("bypass_rt",      32'(bus.bypass_rt),      32'(e.brt));
                check("retired_count",  32'(retired_count),      32'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        s = idle(); s.rst = 1;
        apply(s); apply(s);
        apply(idle());
        // ALU writeback rd=5
        s = idle(); s.valid = 1; s.rw = 1; s.rd = 5; s.alu = 32'h1234;
        apply(s); apply(idle()); apply(idle());
        // $0 write, id_rs=0 while it is in WB
        s = idle(); s.valid = 1; s.rw = 1; s.rd = 0; s.alu = 32'hABCD;
        apply(s);
        s = idle(); s.id_rs = 0; s.id_rt = 0;
        apply(s); apply(idle());
        // lw rd=8 held by a 3-cycle stall, then released
        s = idle(); s.valid = 1; s.rw = 1; s.m2r = 1; s.rd = 8; s.rdata = 32'hDEAD; s.alu = 32'h77;
        apply(s);
        s = idle(); s.stl = 1; s.valid = 1; s.rw = 1; s.rd = 9; s.alu = 32'h99; s.id_rs = 8;
        apply(s); apply(s); apply(s);
        s.stl = 0;
        apply(s);
        // flush with mem_valid=1, including flush during stall
        s = idle(); s.fls = 1; s.valid = 1; s.rw = 1; s.rd = 3; s.alu = 32'h33;
        apply(s);
        s.fls = 0;
        apply(s);
        s.stl = 1; s.fls = 1;
        apply(s); apply(idle());
        // jal: link overrides memToReg
        s = idle(); s.valid = 1; s.rw = 1; s.link = 1; s.m2r = 1; s.rd = 31;
        s.pc4 = 32'h400; s.rdata = 32'h5555; s.alu = 32'h6666;
        apply(s);
        s = idle(); s.id_rs = 4; s.id_rt = 31;
        apply(s); apply(idle());
        // Reset while stalling a valid entry: dropped, not counted
        s = idle(); s.valid = 1; s.rw = 1; s.rd = 7; s.alu = 32'h70;
        apply(s);
        s = idle(); s.stl = 1; s.rst = 1;
        apply(s); apply(idle());
`ifdef LOAD_EXT_EN
        s = idle(); s.valid = 1; s.rw = 1; s.m2r = 1; s.rd = 2; s.rdata = 32'h80FF_0000;
        s.lt = 2'b01; s.off = 2'd3; apply(s);
        s.lt = 2'b10; apply(s);
        s.lt = 2'b11; s.off = 2'd3; apply(s);
        s.lt = 2'b11; s.off = 2'd2; apply(s);
        apply(idle());
`endif
        // Random traffic; small register range makes bypass hits and $0 writes common
        for (int i = 0; i < 500; i++) begin
            s.rst   = ($urandom_range(0, 49) == 0);
            s.stl   = ($urandom_range(0, 3) == 0);
            s.fls   = ($urandom_range(0, 7) == 0);
            s.valid = ($urandom_range(0, 4) != 0);
            s.rw    = ($urandom_range(0, 3) != 0);
            s.m2r   = 1'($urandom);
            s.link  = ($urandom_range(0, 5) == 0);
            s.rd    = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            s.id_rs = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            s.id_rt = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            s.alu   = $urandom;
            s.rdata = $urandom;
            s.pc4   = $urandom;
            s.lt    = 2'($urandom);
            s.off   = 2'($urandom);
            apply(s);
        end
        apply(idle());
        @(negedge clk);
        @(negedge clk);
        #2;
        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
